prog_mod_counter: RTL and testbench

//  Runtime-programmable modulus counter / tick generator; generalises the fixed mod-M counter.

---
 rtl/prog_mod_counter.sv | 111 +++++++++++
 tb/tb_prog_mod_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// prog_mod_counter
//   Runtime-programmable modulus counter and tick generator. Counts up or
//   down modulo m_act, emits a terminal-count pulse, a ~50% duty square
//   wave and a running count of wrap events. A new modulus is requested via
//   m_load and only takes effect when the count is reloaded (wrap or clear),
//   so the count never exceeds the active modulus.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   en        count enable
//   clr       synchronous clear, overrides en
//   dir       0 = up, 1 = down
//   m_in      requested modulus (values below 2 are clamped to 2)
//   m_load    one-cycle request to capture m_in
//   m_ack     one-cycle pulse after a pending modulus became active
//   m_act     modulus currently in effect
//   q         count value
//   max_tick  terminal-count pulse (combinational from registers + en/clr)
//   sq        square output, high while q >= m_act/2
//   wrap_cnt  number of max_tick events, modulo 2^W
module prog_mod_counter #(
    parameter int N         = 8,
    parameter int M_DEFAULT = 15,
    parameter int W         = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic         dir,
    input  logic [N-1:0] m_in,
    input  logic         m_load,
    output logic         m_ack,
    output logic [N-1:0] m_act,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         sq,
    output logic [W-1:0] wrap_cnt
);

    localparam logic [N-1:0] ONE   = N'(1);
    localparam logic [N-1:0] TWO   = N'(2);
    localparam logic [N-1:0] M_RST = N'(M_DEFAULT);

    logic [N-1:0] shadow;
    logic         pending;
    logic         term;
    logic         apply;
    logic [N-1:0] m_new;
    logic [N-1:0] q_next;

    // Terminal condition depends on the current direction.
    always_comb begin
        term = dir ? (q == '0) : (q == m_act - ONE);
    end

    // Gated by reset_n so the pulse stays low while reset is held
    // (q=0 in down mode would otherwise look terminal).
    assign max_tick = reset_n & en & ~clr & term;

    // Modulus changes only on an edge where q is reloaded.
    assign apply = max_tick | clr;

    always_comb begin
        m_new = m_act;
        if (apply && pending)
            m_new = shadow;
    end

    always_comb begin
        q_next = q;
        if (clr)
            q_next = '0;
        else if (en) begin
            if (!dir)
                q_next = term ? '0 : q + ONE;
            else
                q_next = term ? m_new - ONE : q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q        <= '0;
            m_act    <= M_RST;
            shadow   <= M_RST;
            pending  <= 1'b0;
            m_ack    <= 1'b0;
            sq       <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            q     <= q_next;
            m_act <= m_new;
            m_ack <= apply & pending;
            // sq is computed from post-edge q and modulus so it tracks q without lag.
            sq    <= (q_next >= (m_new >> 1));
            // A load coinciding with application refills the shadow and stays
            // pending; the old shadow value is what m_new took this edge.
            if (m_load) begin
                shadow  <= (m_in < TWO) ? TWO : m_in;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            if (max_tick)
                wrap_cnt <= wrap_cnt + W'(1);
        end
    end

endmodule

// File: tb/tb_prog_mod_counter.sv
module tb_prog_mod_counter;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        clr;
    logic        dir;
    logic [7:0]  m_in;
    logic        m_load;
    logic        m_ack;
    logic [7:0]  m_act;
    logic [7:0]  q;
    logic        max_tick;
    logic        sq;
    logic [15:0] wrap_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    prog_mod_counter #(.N(8), .M_DEFAULT(15), .W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .clr      (clr),
        .dir      (dir),
        .m_in     (m_in),
        .m_load   (m_load),
        .m_ack    (m_ack),
        .m_act    (m_act),
        .q        (q),
        .max_tick (max_tick),
        .sq       (sq),
        .wrap_cnt (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        dir     = 1'b0;
        m_in    = '0;
        m_load  = 1'b0;
        #12;
        chk("rst_q", 32'(q), 0);
        chk("rst_m_act", 32'(m_act), 15);
        chk("rst_m_ack", 32'(m_ack), 0);
        chk("rst_sq", 32'(sq), 0);
        chk("rst_wrap", 32'(wrap_cnt), 0);
        chk("rst_max_tick", 32'(max_tick), 0);
        reset_n = 1'b1;
        step();

        // 1: free-running up count, modulus 15
        en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            #1;
            chk("t1_q", 32'(q), 32'(k % 15));
            chk("t1_max_tick", 32'(max_tick), 32'((k % 15) == 14));
            chk("t1_sq", 32'(sq), 32'((k % 15) >= 7));
            step();
        end
        chk("t1_q_end", 32'(q), 0);
        chk("t1_wrap", 32'(wrap_cnt), 2);

        // 2: load modulus 5 at q=3, applied at the wrap
        repeat (3) step();
        chk("t2_q3", 32'(q), 3);
        m_in = 8'd5; m_load = 1'b1;
        step();
        m_load = 1'b0;
        chk("t2_q4", 32'(q), 4);
        chk("t2_m_act_hold", 32'(m_act), 15);
        repeat (10) step();
        #1;
        chk("t2_q14", 32'(q), 14);
        chk("t2_tick14", 32'(max_tick), 1);
        chk("t2_no_ack_yet", 32'(m_ack), 0);
        step();
        chk("t2_q_wrap", 32'(q), 0);
        chk("t2_m_act5", 32'(m_act), 5);
        chk("t2_ack", 32'(m_ack), 1);
        chk("t2_wrap3", 32'(wrap_cnt), 3);
        chk("t2_sq0", 32'(sq), 0);
        step();
        chk("t2_q1", 32'(q), 1);
        chk("t2_ack_once", 32'(m_ack), 0);
        repeat (3) step();
        #1;
        chk("t2_q4_term", 32'(q), 4);
        chk("t2_tick_p5", 32'(max_tick), 1);
        chk("t2_sq_hi", 32'(sq), 1);
        step();
        chk("t2_q0_again", 32'(q), 0);
        chk("t2_wrap4", 32'(wrap_cnt), 4);

        // 3: back to 15 via clr, then count down and flip direction
        m_in = 8'd15; m_load = 1'b1;
        step();
        m_load = 1'b0; clr = 1'b1;
        #1;
        chk("t3_clr_no_tick", 32'(max_tick), 0);
        step();
        chk("t3_clr_q", 32'(q), 0);
        chk("t3_m_act15", 32'(m_act), 15);
        chk("t3_clr_ack", 32'(m_ack), 1);
        clr = 1'b0; dir = 1'b1;
        #1;
        chk("t3_down_tick0", 32'(max_tick), 1);
        step();
        chk("t3_down_q14", 32'(q), 14);
        chk("t3_down_wrap", 32'(wrap_cnt), 5);
        chk("t3_down_sq", 32'(sq), 1);
        chk("t3_ack_clear", 32'(m_ack), 0);
        repeat (7) step();
        #1;
        chk("t3_q7", 32'(q), 7);
        chk("t3_sq7", 32'(sq), 1);
        chk("t3_no_tick7", 32'(max_tick), 0);
        dir = 1'b0;
        step();
        chk("t3_flip_q8", 32'(q), 8);
        chk("t3_flip_wrap", 32'(wrap_cnt), 5);

        // 4: loads below 2 clamp to 2
        m_in = 8'd0; m_load = 1'b1;
        step();
        m_in = 8'd1;
        step();
        m_load = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_m_act2", 32'(m_act), 2);
        chk("t4_q0", 32'(q), 0);
        chk("t4_ack", 32'(m_ack), 1);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t4_q", 32'(q), 32'(k % 2));
            chk("t4_sq", 32'(sq), 32'(k % 2));
            chk("t4_max_tick", 32'(max_tick), 32'(k % 2));
            step();
            chk("t4_ack_low", 32'(m_ack), 0);
        end
        chk("t4_wrap8", 32'(wrap_cnt), 8);

        // 5: enable hold and clear priority
        m_in = 8'd15; m_load = 1'b1;
        step();
        m_load = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_m_act15", 32'(m_act), 15);
        repeat (9) step();
        chk("t5_q9", 32'(q), 9);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_hold_tick", 32'(max_tick), 0);
            step();
            chk("t5_hold_q", 32'(q), 9);
        end
        en = 1'b1;
        repeat (3) step();
        chk("t5_q12", 32'(q), 12);
        clr = 1'b1;
        #1;
        chk("t5_clr_tick", 32'(max_tick), 0);
        step();
        chk("t5_clr_q", 32'(q), 0);
        chk("t5_wrap_kept", 32'(wrap_cnt), 8);
        clr = 1'b0;
        repeat (14) step();
        chk("t5_q14", 32'(q), 14);
        en = 1'b0;
        #1;
        chk("t5_term_en0", 32'(max_tick), 0);
        en = 1'b1;
        #1;
        chk("t5_term_en1", 32'(max_tick), 1);
        clr = 1'b1;
        #1;
        chk("t5_term_clr", 32'(max_tick), 0);
        step();
        clr = 1'b0;
        chk("t5_term_clr_q", 32'(q), 0);
        chk("t5_term_clr_wrap", 32'(wrap_cnt), 8);

        // 6: async reset mid-count with a pending load
        m_in = 8'd7; m_load = 1'b1;
        step();
        m_load = 1'b0;
        step();
        chk("t6_q2", 32'(q), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_q", 32'(q), 0);
        chk("t6_rst_m_act", 32'(m_act), 15);
        chk("t6_rst_wrap", 32'(wrap_cnt), 0);
        chk("t6_rst_sq", 32'(sq), 0);
        chk("t6_rst_tick", 32'(max_tick), 0);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t6_no_ack", 32'(m_ack), 0);
            chk("t6_m_act", 32'(m_act), 15);
        end
        chk("t6_q5", 32'(q), 5);
        chk("t6_wrap1", 32'(wrap_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
